// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Optional statistics counters: define BRANCH_PREDICTOR_STATS_EN.
//
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   start_i             run enable; low holds table and stats
//   pred_pc_i           IF PC lookup -> pred_taken_o / pred_target_o
//   upd_*_i             resolved branch from ID (pc, taken, target, pred)
//   mispredict_o        resolved outcome differs from the prediction
//   flush_i             invalidate every entry
//   branch_cnt_o        accepted updates (stats build only)
//   mispred_cnt_o       mispredicts (stats build only)
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [PC_W-1:0] pred_pc_i,
    output logic            pred_taken_o,
    output logic [PC_W-1:0] pred_target_o,
    input  logic            upd_valid_i,
    input  logic [PC_W-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [PC_W-1:0] upd_target_i,
    input  logic            upd_pred_i,
    output logic            mispredict_o,
    input  logic            flush_i
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0]     branch_cnt_o,
    output logic [31:0]     mispred_cnt_o
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic             vld_q [ENTRIES];
    logic [TAG_W-1:0] tag_q [ENTRIES];
    logic [PC_W-1:0]  tgt_q [ENTRIES];
    logic [1:0]       cnt_q [ENTRIES];

    logic [IDX_W-1:0] p_idx;
    logic [TAG_W-1:0] p_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             p_hit;
    logic             u_hit;
    logic             upd_en;
    logic             unused_bits;

    assign p_idx = pred_pc_i[IDX_W+1:2];
    assign p_tag = pred_pc_i[PC_W-1:IDX_W+2];
    assign u_idx = upd_pc_i[IDX_W+1:2];
    assign u_tag = upd_pc_i[PC_W-1:IDX_W+2];

    // Word-aligned PCs: the byte offset never takes part in lookup.
    assign unused_bits = ^{pred_pc_i[1:0], upd_pc_i[1:0]};

    assign p_hit = vld_q[p_idx] && (tag_q[p_idx] == p_tag);
    assign u_hit = vld_q[u_idx] && (tag_q[u_idx] == u_tag);

    assign upd_en = upd_valid_i & start_i;

    assign pred_taken_o  = start_i & ~rst_i & p_hit & cnt_q[p_idx][1];
    assign pred_target_o = pred_taken_o ? tgt_q[p_idx] : '0;
    assign mispredict_o  = upd_en & ~rst_i & (upd_taken_i ^ upd_pred_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                vld_q[i] <= 1'b0;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= 2'b01;
            end
        end else if (start_i && flush_i) begin
            // Flush beats any concurrent update.
            for (int i = 0; i < ENTRIES; i++) begin
                vld_q[i] <= 1'b0;
            end
        end else if (upd_en) begin
            if (u_hit) begin
                if (upd_taken_i) begin
                    tgt_q[u_idx] <= upd_target_i;
                    if (cnt_q[u_idx] != 2'b11) begin
                        cnt_q[u_idx] <= cnt_q[u_idx] + 2'd1;
                    end
                end else if (cnt_q[u_idx] != 2'b00) begin
                    cnt_q[u_idx] <= cnt_q[u_idx] - 2'd1;
                end
            end else if (upd_taken_i) begin
                // Allocate weak-taken, evicting whatever held the slot.
                vld_q[u_idx] <= 1'b1;
                tag_q[u_idx] <= u_tag;
                tgt_q[u_idx] <= upd_target_i;
                cnt_q[u_idx] <= 2'b10;
            end
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branch_cnt_o  <= '0;
            mispred_cnt_o <= '0;
        end else begin
            if (upd_en) begin
                branch_cnt_o <= branch_cnt_o + 32'd1;
            end
            if (mispredict_o) begin
                mispred_cnt_o <= mispred_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_branch_predictor;

    localparam int PC_W = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic [PC_W-1:0] pred_pc_i;
    logic            pred_taken_o;
    logic [PC_W-1:0] pred_target_o;
    logic            upd_valid_i;
    logic [PC_W-1:0] upd_pc_i;
    logic            upd_taken_i;
    logic [PC_W-1:0] upd_target_i;
    logic            upd_pred_i;
    logic            mispredict_o;
    logic            flush_i;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0]     branch_cnt_o;
    logic [31:0]     mispred_cnt_o;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string          name;
        logic [PC_W+1:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    branch_predictor #(.ENTRIES(16), .PC_W(PC_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .pred_pc_i    (pred_pc_i),
        .pred_taken_o (pred_taken_o),
        .pred_target_o(pred_target_o),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i),
        .upd_target_i (upd_target_i),
        .upd_pred_i   (upd_pred_i),
        .mispredict_o (mispredict_o),
        .flush_i      (flush_i)
`ifdef BRANCH_PREDICTOR_STATS_EN
        ,
        .branch_cnt_o (branch_cnt_o),
        .mispred_cnt_o(mispred_cnt_o)
`endif
    );

    task automatic drv(input bit v, input logic [PC_W-1:0] pc,
                       input bit t, input logic [PC_W-1:0] tg,
                       input bit p);
        upd_valid_i  = v;
        upd_pc_i     = pc;
        upd_taken_i  = t;
        upd_target_i = tg;
        upd_pred_i   = p;
    endtask

    task automatic idle();
        drv(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    // Expected {taken, mispredict, target} goes in with the stimulus,
    // comes out once the combinational outputs have settled.
    task automatic probe(input string n, input logic [PC_W-1:0] pc,
                         input bit tk, input bit mp,
                         input logic [PC_W-1:0] tg);
        exp_t e;
        logic [PC_W+1:0] obs;
        pred_pc_i = pc;
        e.name = n;
        e.exp  = {tk, mp, tg};
        sb.push_back(e);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = {pred_taken_o, mispredict_o, pred_target_o};
            compared++;
            assert (obs === e.exp) else begin
                mismatched++;
                $error("FAIL %s observed=%h expected=%h",
                       e.name, obs, e.exp);
            end
        end
    endtask

`ifdef BRANCH_PREDICTOR_STATS_EN
    task automatic check_cnt(input string n, input logic [31:0] obs,
                             input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", n, obs, exp);
        end
    endtask
`endif

    initial begin
        rst_i     = 1'b1;
        start_i   = 1'b1;
        flush_i   = 1'b0;
        pred_pc_i = '0;
        // Update held during reset must be ignored.
        drv(1'b1, 32'h40, 1'b1, 32'h20, 1'b0);
        step();
        step();
        probe("rst_outputs", 32'h40, 0, 0, 32'h0);

        rst_i = 1'b0;
        idle();
        probe("post_rst_40", 32'h40, 0, 0, 32'h0);
        probe("post_rst_any", 32'h1234, 0, 0, 32'h0);
        step();

        // Allocate 0x40; same-cycle lookup sees old contents.
        drv(1'b1, 32'h40, 1'b1, 32'h20, 1'b0);
        probe("alloc_same_cycle", 32'h40, 0, 1, 32'h0);
        step();
        idle();
        probe("alloc_hit", 32'h40, 1, 0, 32'h20);

        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 32'h40, 1'b1, 32'h20, 1'b1);
            probe($sformatf("inc_%0d", i), 32'h40, 1, 0, 32'h20);
            step();
        end

        // 11 -> 10 -> 01
        drv(1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        probe("dec_1", 32'h40, 1, 1, 32'h20);
        step();
        probe("dec_2", 32'h40, 1, 1, 32'h20);
        step();
        idle();
        probe("weak_nt", 32'h40, 0, 0, 32'h0);

        // 01 -> 00 -> 00 (saturate), then taken -> 01
        drv(1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        step();
        step();
        drv(1'b1, 32'h40, 1'b1, 32'h24, 1'b0);
        probe("nt_sat_mp", 32'h40, 0, 1, 32'h0);
        step();
        idle();
        probe("sat_low", 32'h40, 0, 0, 32'h0);
        drv(1'b1, 32'h40, 1'b1, 32'h28, 1'b0);
        step();
        idle();
        probe("retarget", 32'h40, 1, 0, 32'h28);

        // 0x80 shares index 0 with 0x40
        drv(1'b1, 32'h80, 1'b1, 32'h100, 1'b0);
        step();
        idle();
        probe("evict_40", 32'h40, 0, 0, 32'h0);
        probe("new_80", 32'h80, 1, 0, 32'h100);
        probe("low_bits", 32'h83, 1, 0, 32'h100);

        // Not-taken miss leaves the table alone
        drv(1'b1, 32'hC0, 1'b0, 32'h500, 1'b0);
        step();
        idle();
        probe("nt_miss_c0", 32'hC0, 0, 0, 32'h0);
        probe("nt_miss_80", 32'h80, 1, 0, 32'h100);

        // Flush beats same-cycle update
        flush_i = 1'b1;
        drv(1'b1, 32'h44, 1'b1, 32'h300, 1'b0);
        step();
        flush_i = 1'b0;
        idle();
        probe("flush_44", 32'h44, 0, 0, 32'h0);
        probe("flush_80", 32'h80, 0, 0, 32'h0);

        // start_i low gates outputs and holds the table
        drv(1'b1, 32'h48, 1'b1, 32'h400, 1'b0);
        step();
        start_i = 1'b0;
        drv(1'b1, 32'h4C, 1'b1, 32'h1, 1'b0);
        probe("idle_lookup", 32'h48, 0, 0, 32'h0);
        step();
        start_i = 1'b1;
        idle();
        probe("idle_hold_48", 32'h48, 1, 0, 32'h400);
        probe("idle_hold_4c", 32'h4C, 0, 0, 32'h0);

`ifdef BRANCH_PREDICTOR_STATS_EN
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        drv(1'b1, 32'h50, 1'b1, 32'h10, 1'b0);
        step();
        drv(1'b1, 32'h50, 1'b1, 32'h10, 1'b1);
        step();
        drv(1'b1, 32'h54, 1'b0, 32'h0, 1'b0);
        step();
        drv(1'b1, 32'h50, 1'b0, 32'h0, 1'b1);
        step();
        drv(1'b1, 32'h58, 1'b1, 32'h30, 1'b1);
        step();
        idle();
        #1;
        check_cnt("branch_cnt", branch_cnt_o, 32'd5);
        check_cnt("mispred_cnt", mispred_cnt_o, 32'd2);
        rst_i = 1'b1;
        #1;
        check_cnt("branch_cnt_rst", branch_cnt_o, 32'd0);
        check_cnt("mispred_cnt_rst", mispred_cnt_o, 32'd0);
        step();
        rst_i = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL use parameter ENTRIES, default 16: number of table entries, a power of two, 2..256.
REQ-002 The block SHALL use parameter PC_W, default 32: PC and target width.
REQ-003 The block SHALL derive IDX_W = log2(ENTRIES) and TAG_W = PC_W-IDX_W-2 internally; neither is overridable.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port start_i, input, 1 bit: run enable, same meaning as elsewhere in the CPU.
REQ-007 The block SHALL have port pred_pc_i, input, PC_W bits: IF-stage PC to look up.
REQ-008 The block SHALL have port pred_taken_o, output, 1 bit: predict taken for pred_pc_i.
REQ-009 The block SHALL have port pred_target_o, output, PC_W bits: predicted target, valid when pred_taken_o=1.
REQ-010 The block SHALL have port upd_valid_i, input, 1 bit: branch resolved in ID this cycle.
REQ-011 The block SHALL have ports upd_pc_i (PC_W), upd_taken_i (1), upd_target_i (PC_W) and upd_pred_i (1), all inputs: resolved branch PC, actual outcome, actual target, and the prediction made for it.
REQ-012 The block SHALL have port mispredict_o, output, 1 bit: the resolved branch was mispredicted; the pipeline redirects and flushes IF/ID.
REQ-013 The block SHALL have port flush_i, input, 1 bit: invalidate the whole table.

Function
REQ-014 Each entry SHALL hold valid (1), tag (TAG_W), target (PC_W) and a 2-bit saturating counter: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
REQ-015 Index SHALL be pc[IDX_W+1:2] and tag SHALL be pc[PC_W-1:IDX_W+2]; bits [1:0] are ignored.
REQ-016 Lookup SHALL be combinational, zero latency: pred_taken_o = start_i & valid & tag match & counter[1].
REQ-017 pred_target_o SHALL equal the indexed entry's target and SHALL be 0 when pred_taken_o=0.
REQ-018 mispredict_o SHALL be combinational: upd_valid_i & start_i & (upd_taken_i != upd_pred_i).
REQ-019 On a clock edge with upd_valid_i=1, start_i=1 and a hit, the counter SHALL increment if taken and decrement if not taken, saturating at 11 and 00; on taken the target is rewritten.
REQ-020 On a miss with upd_taken_i=1, the entry SHALL be allocated (overwriting any valid entry): valid=1, tag, target, counter=10.
REQ-021 On a miss with upd_taken_i=0, the table SHALL be unchanged.
REQ-022 Table writes SHALL take effect at the clock edge; a same-cycle lookup of the index being updated returns the pre-update contents.
REQ-023 flush_i=1 SHALL clear all valid bits at the edge; if an update occurs in the same cycle, flush wins and the update is discarded.
REQ-024 With start_i=0, the table and the statistics SHALL hold, and pred_taken_o and mispredict_o SHALL be 0.

Reset
REQ-025 rst_i=1 SHALL asynchronously clear all valid bits, set all counters to 01, and clear all targets, tags and statistics counters.
REQ-026 During reset, pred_taken_o=0, pred_target_o=0 and mispredict_o=0; reset asserted mid-update discards the update.

Configuration
REQ-027 The block SHALL support the macro BRANCH_PREDICTOR_STATS_EN.
REQ-028 With BRANCH_PREDICTOR_STATS_EN defined, the block SHALL add outputs branch_cnt_o (32) and mispred_cnt_o (32), counting accepted updates and mispredicts (REQ-018); both wrap at 2^32 and are unaffected by flush_i.
REQ-029 With BRANCH_PREDICTOR_STATS_EN undefined, those ports and their registers SHALL be absent; all other behaviour is identical.

Verification
REQ-030 The bench SHALL check: after reset, a lookup of any PC -> pred_taken_o=0 and pred_target_o=0.
REQ-031 The bench SHALL check: an update with pc=0x40, taken, target=0x20, pred=0 -> mispredict_o=1 that cycle; then a lookup of 0x40 -> pred_taken_o=1 and pred_target_o=0x20.
REQ-032 The bench SHALL check: after three further taken updates of 0x40, then two not-taken updates -> counter 11, then 01, and a lookup of 0x40 gives pred_taken_o=0.
REQ-033 The bench SHALL check, with ENTRIES=16: 0x40 is allocated, then an update with pc=0x80 (same index, different tag), taken, target=0x100 -> a lookup of 0x40 misses and a lookup of 0x80 gives target 0x100.
REQ-034 The bench SHALL check: flush_i and a taken update of 0x44 in the same cycle -> a lookup of 0x44 gives pred_taken_o=0.
REQ-035 The bench SHALL check, with BRANCH_PREDICTOR_STATS_EN defined: 5 updates of which 2 mispredict -> branch_cnt_o=5 and mispred_cnt_o=2; after rst_i pulses -> both 0.
